// File: rtl/pipeline_run_ctrl.sv
// Run controller for the MIPS core: sequences core reset, locks the forwarding mode per run,
// enforces a RUN-cycle budget and counts cycles/retires. Optional stall counter: RUN_CTRL_STALL_CNT_EN.
module pipeline_run_ctrl #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned MAX_CYCLES   = 35
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             fwd_mode_in,
   input  logic             halt_req,
   input  logic             retire_valid,
   output logic             core_rst,
   output logic             forwarding_EN,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
`ifdef RUN_CTRL_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_count
`endif
);

   localparam int unsigned             RST_CNT_W = 4;
   localparam logic [RST_CNT_W-1:0]    RST_LAST  = RST_CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]        CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      RESET,
      RUN,
      DONE
   } state_t;

   state_t               state;
   logic [RST_CNT_W-1:0] rst_cnt;

   // Single-process FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rst_cnt       <= '0;
         core_rst      <= 1'b1;
         forwarding_EN <= 1'b0;
         running       <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         cycle_count   <= '0;
         retire_count  <= '0;
`ifdef RUN_CTRL_STALL_CNT_EN
         stall_count   <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= RESET;
                  rst_cnt       <= '0;
                  core_rst      <= 1'b1;
                  forwarding_EN <= fwd_mode_in;
                  done          <= 1'b0;
                  timeout       <= 1'b0;
                  cycle_count   <= '0;
                  retire_count  <= '0;
`ifdef RUN_CTRL_STALL_CNT_EN
                  stall_count   <= '0;
`endif
               end
            end
            RESET: begin
               if (rst_cnt == RST_LAST) begin
                  state    <= RUN;
                  core_rst <= 1'b0;
                  running  <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + RST_CNT_W'(1);
               end
            end
            RUN: begin
               // The ending edge still applies its increments.
               cycle_count <= cycle_count + CNT_W'(1);
               if (retire_valid && (retire_count != CNT_MAX)) begin
                  retire_count <= retire_count + CNT_W'(1);
               end
`ifdef RUN_CTRL_STALL_CNT_EN
               if (!retire_valid && (stall_count != CNT_MAX)) begin
                  stall_count <= stall_count + CNT_W'(1);
               end
`endif
               if (halt_req || (cycle_count == CYC_LAST)) begin
                  state    <= DONE;
                  core_rst <= 1'b1;
                  running  <= 1'b0;
                  done     <= 1'b1;
                  timeout  <= !halt_req;
               end
            end
            default: begin
               state    <= IDLE;
               core_rst <= 1'b1;
               running  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: directed runs plus random traffic against
// an elapsed-edge reference model.
module tb_pipeline_run_ctrl;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned RESET_CYCLES = 2;
   localparam int unsigned MAX_CYCLES   = 35;
   localparam int          CNT_SAT      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             fwd_mode_in;
   logic             halt_req;
   logic             retire_valid;
   logic             core_rst;
   logic             forwarding_EN;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] retire_count;
`ifdef RUN_CTRL_STALL_CNT_EN
   logic [CNT_W-1:0] stall_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: a run is "active" from its accepted start until it ends;
   // the phase is derived from the number of edges elapsed since that start.
   bit m_active;
   int m_edges;
   int m_cyc;
   int m_ret;
   int m_stall;
   bit m_done;
   bit m_to;
   bit m_fwd;

   always #5 clk = ~clk;

   pipeline_run_ctrl #(
      .CNT_W       (CNT_W),
      .RESET_CYCLES(RESET_CYCLES),
      .MAX_CYCLES  (MAX_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .fwd_mode_in  (fwd_mode_in),
      .halt_req     (halt_req),
      .retire_valid (retire_valid),
      .core_rst     (core_rst),
      .forwarding_EN(forwarding_EN),
      .running      (running),
      .done         (done),
      .timeout      (timeout),
      .cycle_count  (cycle_count),
      .retire_count (retire_count)
`ifdef RUN_CTRL_STALL_CNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_running();
      return m_active && (m_edges >= int'(RESET_CYCLES));
   endfunction

   function automatic void model_reset();
      m_active = 1'b0;
      m_edges  = 0;
      m_cyc    = 0;
      m_ret    = 0;
      m_stall  = 0;
      m_done   = 1'b0;
      m_to     = 1'b0;
      m_fwd    = 1'b0;
   endfunction

   function automatic void model_edge();
      bit run_edge;
      if (!m_active) begin
         if (start) begin
            m_active = 1'b1;
            m_edges  = 0;
            m_fwd    = fwd_mode_in;
            m_cyc    = 0;
            m_ret    = 0;
            m_stall  = 0;
            m_done   = 1'b0;
            m_to     = 1'b0;
         end
      end else begin
         run_edge = m_running();
         m_edges++;
         if (run_edge) begin
            m_cyc++;
            if (retire_valid) m_ret = (m_ret < CNT_SAT) ? m_ret + 1 : m_ret;
            else m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : m_stall;
            if (halt_req || (m_cyc == int'(MAX_CYCLES))) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_to     = !halt_req;
            end
         end
      end
   endfunction

   task automatic compare_all();
      chk("core_rst", core_rst, !m_running());
      chk("forwarding_EN", forwarding_EN, m_fwd);
      chk("running", running, m_running());
      chk("done", done, m_done);
      chk("timeout", timeout, m_to);
      chk("cycle_count", cycle_count, m_cyc);
      chk("retire_count", retire_count, m_ret);
`ifdef RUN_CTRL_STALL_CNT_EN
      chk("stall_count", stall_count, m_stall);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      compare_all();
   endtask

   // Called just after an edge; the pulse lies fully between edges.
   task automatic pulse_rst();
      #3 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("arst_core_rst", core_rst, 1);
      chk("arst_running", running, 0);
      chk("arst_cycle", cycle_count, 0);
      #1 rst = 1'b0;
   endtask

   // One run: start with mode fwd, halt on RUN edge halt_at (0 = never),
   // retire on the first rv_n RUN edges; start/fwd/halt are noisy where they must be ignored.
   task automatic do_run(input bit fwd, input int halt_at, input int rv_n);
      int idx = 0;
      start       = 1'b1;
      fwd_mode_in = fwd;
      halt_req    = 1'b1;
      step();
      chk("start_fwd", forwarding_EN, fwd);
      chk("start_core_rst", core_rst, 1);
      chk("start_done_clr", done, 0);
      chk("start_cyc_clr", cycle_count, 0);
      chk("start_ret_clr", retire_count, 0);
      start       = 1'(~fwd);
      fwd_mode_in = 1'(~fwd);
      step();
      chk("rst_phase_core_rst", core_rst, 1);
      chk("rst_phase_running", running, 0);
      step();
      chk("run_core_rst", core_rst, 0);
      chk("run_running", running, 1);
      chk("run_cyc0", cycle_count, 0);
      for (int n = 0; n < 100 && !m_done; n++) begin
         idx++;
         start        = 1'($urandom);
         fwd_mode_in  = 1'($urandom);
         halt_req     = (idx == halt_at);
         retire_valid = (idx <= rv_n);
         step();
      end
      if (!m_done) chk("run_bound", 0, 1);
      start        = 1'b0;
      halt_req     = 1'b0;
      retire_valid = 1'b0;
      chk("end_fwd_locked", forwarding_EN, fwd);
      chk("end_core_rst", core_rst, 1);
      chk("end_done", done, 1);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      fwd_mode_in  = 1'b0;
      halt_req     = 1'b0;
      retire_valid = 1'b0;
      model_reset();
      #100;
      chk("reset_core_rst", core_rst, 1);
      chk("reset_fwd", forwarding_EN, 0);
      chk("reset_running", running, 0);
      chk("reset_done", done, 0);
      chk("reset_timeout", timeout, 0);
      chk("reset_cycle", cycle_count, 0);
      chk("reset_retire", retire_count, 0);
      rst = 1'b0;

      // Timeout run with a retire every cycle
      do_run(1'b1, 0, 1000);
      chk("to_timeout", timeout, 1);
      chk("to_cycle", cycle_count, 35);
      chk("to_retire", retire_count, 35);

      // Restart from DONE with forwarding off; halt on RUN edge 10
      do_run(1'b0, 10, 6);
      chk("halt_timeout", timeout, 0);
      chk("halt_cycle", cycle_count, 10);
      chk("halt_retire", retire_count, 6);
`ifdef RUN_CTRL_STALL_CNT_EN
      chk("halt_stall", stall_count, 4);
`endif

      // Halt coincides with budget exhaustion
      do_run(1'b1, 35, 20);
      chk("sim_timeout", timeout, 0);
      chk("sim_cycle", cycle_count, 35);
      chk("sim_retire", retire_count, 20);

      // Done holds with idle inputs; halt/retire ignored outside RUN
      for (int n = 0; n < 5; n++) begin
         halt_req     = 1'($urandom);
         retire_valid = 1'($urandom);
         fwd_mode_in  = 1'($urandom);
         step();
      end
      chk("hold_cycle", cycle_count, 35);

      // Async reset mid-run
      start       = 1'b1;
      fwd_mode_in = 1'b1;
      step();
      start = 1'b0;
      for (int n = 0; n < 6; n++) begin
         retire_valid = 1'($urandom);
         step();
      end
      pulse_rst();
      chk("arst_fwd", forwarding_EN, 0);
      for (int n = 0; n < 3; n++) step();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         start        = ($urandom_range(0, 15) == 0);
         fwd_mode_in  = 1'($urandom);
         halt_req     = ($urandom_range(0, 24) == 0);
         retire_valid = 1'($urandom);
         step();
         if ($urandom_range(0, 299) == 0) pulse_rst();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
